demux32x4_buf: RTL and testbench

- Buffered 1-to-4 demultiplexer for the 32-bit datapath; it is the distribution counterpart of the 4-input 32-bit selector.
- Accepts one 32-bit word plus a 2-bit destination select through a valid/ready handshake.
- Queues the word in a small per-destination FIFO and presents it on that destination's valid/ready output channel.
- Sits between a shared result source (ALU/mult-div/load path) and up to four independent consumers (write-back, HI/LO, store path, debug).

---
 rtl/demux32x4_buf_pkg.sv | 16 +
 rtl/demux_chan_fifo.sv | 80 ++++++++
 rtl/demux32x4_buf.sv | 85 ++++++++
 tb/tb_demux32x4_buf.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux32x4_buf_pkg.sv
// Shared constants for the buffered 1-to-4 32-bit demultiplexer.
// Provides the default word width, the destination count, the select width
// and the symbolic destination indices used by producers and consumers.
package demux32x4_buf_pkg;

   localparam int unsigned WIDTH_DEF = 32;
   localparam int unsigned NUM_DEST  = 4;
   localparam int unsigned SEL_W     = 2;

   // Destination indices on in_select
   localparam logic [SEL_W-1:0] DEST_WB   = 2'd0;
   localparam logic [SEL_W-1:0] DEST_HILO = 2'd1;
   localparam logic [SEL_W-1:0] DEST_MEM  = 2'd2;
   localparam logic [SEL_W-1:0] DEST_DBG  = 2'd3;

endpackage

// File: rtl/demux_chan_fifo.sv
// Single-clock per-destination FIFO with registered head word and flags.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   push, wdata write strobe and word (ignored when full and not popping)
//   pop         read strobe (ignored when empty)
//   rdata       registered head word, 0 after reset
//   full, empty registered occupancy flags
//   level       registered occupancy 0..DEPTH
module demux_chan_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_n [DEPTH];
   logic [AW-1:0]    wr_q, wr_n, rd_q, rd_n;
   logic [LW-1:0]    lvl_n;
   logic             push_ok, pop_ok;

   // Protect storage against producer/consumer misuse
   assign push_ok = push & (~full | pop);
   assign pop_ok  = pop & ~empty;

   // Next-state storage, pointers and level
   always_comb begin
      mem_n = mem_q;
      wr_n  = wr_q;
      rd_n  = rd_q;
      lvl_n = level;
      if (push_ok) begin
         mem_n[wr_q] = wdata;
         wr_n        = wr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_n = rd_q + AW'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   lvl_n = level + LW'(1);
         2'b01:   lvl_n = level - LW'(1);
         default: lvl_n = level;
      endcase
   end

   // Head word and flags are registered from next state so outputs come from flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_q  <= '0;
         rd_q  <= '0;
         level <= '0;
         rdata <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         mem_q <= mem_n;
         wr_q  <= wr_n;
         rd_q  <= rd_n;
         level <= lvl_n;
         rdata <= mem_n[rd_n];
         full  <= (lvl_n == LW'(DEPTH));
         empty <= (lvl_n == '0);
      end
   end

endmodule

// File: rtl/demux32x4_buf.sv
// Buffered 1-to-4 demultiplexer: routes a word to one of four per-destination
// FIFOs selected by in_select, each with its own valid/ready output channel.
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   in_valid/in_ready     input handshake (in_ready is combinational)
//   in_data, in_select    word and destination index, sampled on transfer
//   out_valid/out_ready   per-destination handshake, bit i = destination i
//   out_data0..3          registered head word of each destination
//   out_level             per-destination occupancy, destination i in slice i
//   accept_count          wrapping count of accepted words
module demux32x4_buf
   import demux32x4_buf_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = 16
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [WIDTH-1:0]                       in_data,
   input  logic [SEL_W-1:0]                       in_select,
   output logic [NUM_DEST-1:0]                    out_valid,
   input  logic [NUM_DEST-1:0]                    out_ready,
   output logic [WIDTH-1:0]                       out_data0,
   output logic [WIDTH-1:0]                       out_data1,
   output logic [WIDTH-1:0]                       out_data2,
   output logic [WIDTH-1:0]                       out_data3,
   output logic [NUM_DEST*($clog2(DEPTH)+1)-1:0]  out_level,
   output logic [CNT_W-1:0]                       accept_count
);

   localparam int unsigned LW = $clog2(DEPTH) + 1;

   logic [NUM_DEST-1:0] push, pop, full, empty;
   logic [WIDTH-1:0]    rdata [NUM_DEST];
   logic [LW-1:0]       lvl   [NUM_DEST];
   logic                xfer;

   // A full destination still accepts when it pops in the same cycle
   always_comb begin
      in_ready = rst_n & (~full[in_select] | out_ready[in_select]);
   end

   assign xfer = in_valid & in_ready;

   for (genvar g = 0; g < int'(NUM_DEST); g++) begin : g_chan
      assign push[g] = xfer & (in_select == SEL_W'(g));
      assign pop[g]  = ~empty[g] & out_ready[g];

      demux_chan_fifo #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst_n (rst_n),
         .push  (push[g]),
         .pop   (pop[g]),
         .wdata (in_data),
         .rdata (rdata[g]),
         .full  (full[g]),
         .empty (empty[g]),
         .level (lvl[g])
      );

      assign out_level[g*LW +: LW] = lvl[g];
   end

   assign out_valid = ~empty;
   assign out_data0 = rdata[0];
   assign out_data1 = rdata[1];
   assign out_data2 = rdata[2];
   assign out_data3 = rdata[3];

   // Accepted-word counter, wraps naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         accept_count <= '0;
      end else if (xfer) begin
         accept_count <= accept_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_demux32x4_buf.sv
// Scoreboard bench for demux32x4_buf: the driver records each accepted word in
// a per-destination expected queue; a negedge monitor compares valid, level,
// head data and in_ready against those queues and retires popped words.
module tb_demux32x4_buf;
   import demux32x4_buf_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [1:0]  in_select;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [31:0] out_data0, out_data1, out_data2, out_data3;
   logic [7:0]  out_level;
   logic [15:0] accept_count;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;
   bit rnd_en = 1'b0;

   logic [31:0] mq [4][1024];
   int          head [4];
   int          tail [4];

   demux32x4_buf #(.WIDTH(32), .DEPTH(2), .CNT_W(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_select    (in_select),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data0    (out_data0),
      .out_data1    (out_data1),
      .out_data2    (out_data2),
      .out_data3    (out_data3),
      .out_level    (out_level),
      .accept_count (accept_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] dout(input int i);
      case (i)
         0:       return out_data0;
         1:       return out_data1;
         2:       return out_data2;
         default: return out_data3;
      endcase
   endfunction

   function automatic logic [1:0] lvl(input int i);
      return 2'(out_level >> (2 * i));
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 4; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end
   endtask

   // Present a word and wait (bounded) for it to be accepted
   task automatic send(input logic [31:0] d, input int s);
      bit done = 1'b0;
      in_data   = d;
      in_select = 2'(s);
      in_valid  = 1'b1;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            mq[s][tail[s] % 1024] = d;
            tail[s]++;
            done = 1'b1;
         end else begin
            @(posedge clk);
         end
      end
      #1;
      in_valid = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_timeout sel=%0d: got no accept, expected accept", s);
      end
   endtask

   // Monitor: compare against model occupancy, then retire words popped at the next edge
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         int sz [4];
         for (int i = 0; i < 4; i++) sz[i] = tail[i] - head[i];
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'(sz[i] != 0));
            chk($sformatf("out_level[%0d]", i), 32'(lvl(i)), 32'(sz[i]));
            if (sz[i] != 0)
               chk($sformatf("out_data%0d", i), dout(i), mq[i][head[i] % 1024]);
         end
         chk("in_ready", 32'(in_ready),
             32'((sz[in_select] < 2) || out_ready[in_select]));
         for (int i = 0; i < 4; i++)
            if (sz[i] != 0 && out_ready[i]) head[i]++;
      end
   end

   // Random consumer back-pressure during the streaming phase
   always @(posedge clk) begin
      #1;
      if (rnd_en) out_ready = 4'($urandom);
   end

   initial begin
      clear_model();
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h0;
      in_select = 2'd0;
      out_ready = 4'h0;

      // Reset held with in_valid asserted
      repeat (3) @(posedge clk);
      #1;
      chk("rst in_ready", 32'(in_ready), 32'h0);
      chk("rst out_valid", 32'(out_valid), 32'h0);
      chk("rst accept_count", 32'(accept_count), 32'h0);
      chk("rst out_level", 32'(out_level), 32'h0);
      chk("rst out_data0", out_data0, 32'h0);
      rst_n = 1'b1;
      #1;
      chk("post-rst in_ready", 32'(in_ready), 32'h1);
      in_valid = 1'b0;
      mon_en   = 1'b1;

      // Routing and one-cycle latency
      send(32'hDEADBEEF, DEST_MEM);
      send(32'h00000001, DEST_WB);
      chk("route out_valid", 32'(out_valid), 32'h5);
      chk("route out_data2", out_data2, 32'hDEADBEEF);
      chk("route out_data0", out_data0, 32'h00000001);
      chk("route accept_count", 32'(accept_count), 32'd2);
      out_ready = 4'hF;
      repeat (2) @(posedge clk);
      #1 out_ready = 4'h0;

      // Full destination 1 does not block destination 3
      send(32'hA, DEST_HILO);
      send(32'hB, DEST_HILO);
      chk("full level1", 32'(lvl(1)), 32'd2);
      in_select = DEST_HILO;
      in_data   = 32'h77;
      in_valid  = 1'b1;
      #1;
      chk("full in_ready sel1", 32'(in_ready), 32'h0);
      in_select = DEST_DBG;
      #1;
      chk("full in_ready sel3", 32'(in_ready), 32'h1);
      send(32'h33, DEST_DBG);
      chk("hol accept_count", 32'(accept_count), 32'd5);

      // Push into a full FIFO while it pops
      out_ready = 4'b0010;
      send(32'hC, DEST_HILO);
      chk("pp level1", 32'(lvl(1)), 32'd2);
      chk("pp out_data1", out_data1, 32'hB);
      repeat (2) @(posedge clk);
      #1 out_ready = 4'hF;
      repeat (2) @(posedge clk);
      #1 out_ready = 4'h0;
      chk("pp drained", 32'(out_valid), 32'h0);

      // Asynchronous reset pulse with every FIFO occupied
      for (int i = 0; i < 4; i++) send(32'h100 + 32'(i), i);
      chk("pre-rst out_valid", 32'(out_valid), 32'hF);
      #1;
      rst_n = 1'b0;
      clear_model();
      #1;
      chk("async out_valid", 32'(out_valid), 32'h0);
      chk("async out_level", 32'(out_level), 32'h0);
      chk("async in_ready", 32'(in_ready), 32'h0);
      chk("async accept_count", 32'(accept_count), 32'h0);
      chk("async out_data2", out_data2, 32'h0);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1 out_ready = 4'hF;
      repeat (3) @(posedge clk);
      #1;
      chk("no stale out_valid", 32'(out_valid), 32'h0);

      // Random stream with random back-pressure
      rnd_en = 1'b1;
      for (int n = 0; n < 1000; n++) send($urandom, int'($urandom_range(0, 3)));
      rnd_en = 1'b0;
      out_ready = 4'hF;
      repeat (10) @(posedge clk);
      #1;
      chk("stream accept_count", 32'(accept_count), 32'd1000);
      chk("stream out_valid", 32'(out_valid), 32'h0);
      for (int i = 0; i < 4; i++)
         chk($sformatf("stream model empty %0d", i), 32'(tail[i] - head[i]), 32'h0);

      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
